// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive end of a 4-channel time-division serial link.
//
// Recovers frame alignment from frame_sync. Each slot is shifted in MSB
// first, and all four channel words are presented together once a complete
// frame has arrived. A frame is 4 slots of DATA_W bits.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   din         serial data bit
//   din_valid   qualifies din / frame_sync; a clock edge with din_valid=1 is a beat
//   frame_sync  high on the beat carrying the MSB of slot 0
//   y           registered channel words, y[k*DATA_W +: DATA_W] = channel k
//   y_valid     one-cycle pulse when y has been updated with a complete frame
//   sel         slot currently being received (0 while hunting)
//   locked      high while frame alignment is held
//   sync_err    one-cycle pulse on a framing violation
module tdm_demux4 #(
  parameter int DATA_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din,
  input  logic                  din_valid,
  input  logic                  frame_sync,
  output logic [4*DATA_W-1:0]   y,
  output logic                  y_valid,
  output logic [1:0]            sel,
  output logic                  locked,
  output logic                  sync_err
);

  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W);

  logic [0:0]          state_r;
  logic [CW-1:0]       cnt_r;
  logic [1:0]          sel_r;
  logic [DATA_W-1:0]   shift_r;
  logic [DATA_W-1:0]   stage0_r;
  logic [DATA_W-1:0]   stage1_r;
  logic [DATA_W-1:0]   stage2_r;
  logic [4*DATA_W-1:0] y_r;
  logic                y_valid_r;
  logic                sync_err_r;
  logic                locked_r;

  logic                take_s;      // beat is shifted into the current slot
  logic                restart_s;   // beat starts a fresh frame (bit 0 of slot 0)
  logic                err_s;       // framing violation on this beat
  logic                hunt_s;      // lose alignment and return to HUNT
  logic                start_s;     // receiver sits at the first beat of a frame
  logic [CW-1:0]       cnt_eff_s;
  logic [1:0]          sel_eff_s;
  logic [CW-1:0]       cnt_inc_s;
  logic [DATA_W-1:0]   word_s;
  logic                slot_done_s;
  logic                frame_done_s;

  assign start_s = (cnt_r == {CW{1'b0}}) && (sel_r == 2'd0);

  // Classify each beat: discard, shift, restart a frame, or drop alignment.
  always_comb begin
    take_s    = 1'b0;
    restart_s = 1'b0;
    err_s     = 1'b0;
    hunt_s    = 1'b0;
    if (din_valid) begin
      if (state_r == HUNT) begin
        if (frame_sync) begin
          take_s    = 1'b1;
          restart_s = 1'b1;
        end else begin
          take_s    = 1'b0;
        end
      end else if (start_s) begin
        if (frame_sync) begin
          take_s = 1'b1;
        end else begin
          err_s  = 1'b1;
          hunt_s = 1'b1;
        end
      end else if (frame_sync) begin
        // Early sync: abandon the partial frame, this beat opens a new one.
        err_s     = 1'b1;
        take_s    = 1'b1;
        restart_s = 1'b1;
      end else begin
        take_s = 1'b1;
      end
    end else begin
      take_s = 1'b0;
    end
  end

  // Next-word datapath; a restart behaves as if counters were already zero.
  always_comb begin
    cnt_eff_s    = restart_s ? {CW{1'b0}} : cnt_r;
    sel_eff_s    = restart_s ? 2'd0 : sel_r;
    cnt_inc_s    = cnt_eff_s + CW'(1);
    word_s       = shift_r << 1;
    word_s[0]    = din;
    slot_done_s  = (cnt_inc_s == CNT_LAST);
    frame_done_s = take_s && slot_done_s && (sel_eff_s == 2'd3);
  end

  // Framing state, slot counters, staging registers and output words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= HUNT;
      cnt_r      <= {CW{1'b0}};
      sel_r      <= 2'd0;
      shift_r    <= {DATA_W{1'b0}};
      stage0_r   <= {DATA_W{1'b0}};
      stage1_r   <= {DATA_W{1'b0}};
      stage2_r   <= {DATA_W{1'b0}};
      y_r        <= {(4*DATA_W){1'b0}};
      y_valid_r  <= 1'b0;
      sync_err_r <= 1'b0;
      locked_r   <= 1'b0;
    end else begin
      y_valid_r  <= frame_done_s;
      sync_err_r <= err_s;
      if (take_s) begin
        state_r  <= RECV;
        locked_r <= 1'b1;
        shift_r  <= word_s;
        if (slot_done_s) begin
          cnt_r <= {CW{1'b0}};
          sel_r <= sel_eff_s + 2'd1;
          case (sel_eff_s)
            2'd0:    stage0_r <= word_s;
            2'd1:    stage1_r <= word_s;
            2'd2:    stage2_r <= word_s;
            // Slot 3 word goes straight to y with the staged words.
            default: y_r <= {word_s, stage2_r, stage1_r, stage0_r};
          endcase
        end else begin
          cnt_r <= cnt_inc_s;
          sel_r <= sel_eff_s;
        end
      end else if (hunt_s) begin
        state_r  <= HUNT;
        locked_r <= 1'b0;
        sel_r    <= 2'd0;
        cnt_r    <= {CW{1'b0}};
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign y        = y_r;
  assign y_valid  = y_valid_r;
  assign sel      = sel_r;
  assign locked   = locked_r;
  assign sync_err = sync_err_r;

endmodule
